fpu: RTL and testbench
======================

Name: fpu

Overview:
- Multi-cycle single-precision (IEEE-754 binary32) arithmetic unit: add, subtract, multiply, divide.
- Sits beside the integer datapath as a request/acknowledge slave.
  - Accepts one operation at a time through an input handshake.
  - Returns one 32-bit result through an output handshake.

Parameters:
- None. Format fixed at binary32: 1 sign bit, 8 exponent bits (bias 127), 23 fraction bits.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- operation  in  4  Operation_t opcode: 4'b0000 ADD, 4'b0001 SUB, 4'b0010 MUL, 4'b0011 DIV; other codes reserved.
- data_a  in  32  left operand (binary32).
- data_b  in  32  right operand (binary32).
- input_rdy  in  1  requester has a valid operation and operands.
- input_ack  out  1  operation captured; held until the result is consumed.
- output_rdy  out  1  result valid.
- output_ack  in  1  requester has consumed the result.
- result  out  32  binary32 result.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; input_ack=0, output_rdy=0, result=0; all internal registers cleared.
  - Reset mid-operation aborts the operation; no result is produced.
- States: IDLE -> UNPACK -> SPECIAL -> COMPUTE -> NORMALIZE -> DONE -> IDLE.
- IDLE:
  - When input_rdy=1 on a clock edge, register operation, data_a and data_b, and set input_ack=1.
  - Inputs are ignored in every other state.
- UNPACK:
  - Split sign, exponent and fraction; prepend the hidden 1 when exponent!=0.
  - Exponent 0 operands (zero/denormal) are treated as signed zero: flush-to-zero.
- SPECIAL (priority order, first match wins; a match goes straight to DONE):
  - Any NaN operand, or an invalid operation -> 32'hFFFFFFFF. Invalid operations: Inf-Inf with effectively opposite signs, 0*Inf, 0/0, Inf/Inf.
  - Reserved opcode -> 32'hFFFFFFFF.
  - ADD/SUB with Inf -> that Inf (sign taken from the Inf operand, negated for data_b on SUB).
  - MUL with Inf -> Inf, sign = sa^sb.
  - DIV: x/0 (x finite nonzero) -> Inf, sign sa^sb; Inf/finite -> Inf; finite/Inf -> zero, sign sa^sb.
  - Zero operands:
    - ADD: 0+x -> x.
    - MUL: x*0 -> signed zero, sign sa^sb.
    - DIV: 0/x -> signed zero, sign sa^sb.
- COMPUTE:
  - ADD/SUB (SUB inverts sign of data_b):
    - Align the smaller-exponent mantissa by right shift of the exponent difference; shifts >=25 give 0.
    - Equal signs: add magnitudes. Otherwise subtract smaller magnitude from larger; result sign = sign of the larger magnitude.
    - Exact zero result -> +0.
    - 1 cycle.
  - MUL: 24x24 mantissa product; exponent ea+eb-127; sign sa^sb; 1 cycle.
  - DIV:
    - Restoring shift-subtract over 26 quotient bits, one bit per cycle.
    - Exponent ea-eb+127; sign sa^sb.
- NORMALIZE:
  - Shift the mantissa so the hidden bit sits at bit 23, adjusting the exponent. Right shift by 1 on carry-out; left shift by the leading-zero count after cancellation.
  - Rounding: round toward zero (truncate discarded bits).
  - Exponent >=255 -> signed Inf (8'hFF, fraction 0).
  - Exponent <=0 -> signed zero.
- DONE:
  - result is driven and output_rdy=1; input_ack stays 1.
  - Hold result stable until output_ack=1 on a clock edge.
  - Then clear output_rdy and input_ack and return to IDLE.
  - A new request is accepted no earlier than the cycle after return to IDLE.
- Latency from capture to output_rdy: 5 cycles for ADD/SUB/MUL, 30 cycles for DIV; special cases take 3 cycles.
- output_ack while output_rdy=0 is ignored.

Optional Feature:
- Macro FPU_DIV_EN.
  - Defined: the divider is built and DIV behaves as above.
  - Undefined: no divider logic; DIV is treated as a reserved opcode (result 32'hFFFFFFFF, latency 3).

Test Plan:
- ADD 32'h3F800000 (1.0) + 32'h3C23D70A (0.01) -> output_rdy with input_ack=1, result 32'h3F8147AE (truncated 1.01).
- ADD 32'hBF800000 (-1.0) + 32'h41433333 (12.2) -> 32'h41333333 (11.2). ADD -1.0 + -12.2 (32'hC1433333) -> 32'hC1533333 (-13.2).
- ADD 32'h7E967699 (~1e38) + 32'hBF8CCCCD (-1.1) -> 32'h7E967699. ADD 32'h7F800000 + 32'h3F800000 -> 32'h7F800000.
- ADD two NaNs (32'hFF8CCCCD, 32'h7F8CCCCD) -> 32'hFFFFFFFF. ADD +Inf + -Inf -> 32'hFFFFFFFF.
- MUL 2.0*2.0 (32'h40000000 each) -> 32'h40800000; MUL -2.0*2.0 -> 32'hC0800000.
- DIV 4.0/2.0 (32'h40800000, 32'h40000000) -> 32'h40000000 (FPU_DIV_EN defined).
- Reset asserted mid-DIV -> outputs 0 immediately; subsequent ADD completes normally.
- Result held while output_ack=0 for 10 cycles; after one output_ack, output_rdy and input_ack deassert.

Source files
------------

// File: rtl/fpu.sv
// Multi-cycle binary32 add/sub/mul/div unit behind a request/acknowledge handshake.
// The divider is built only when FPU_DIV_EN is defined; otherwise DIV is a reserved opcode.
module fpu (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  operation,
  input  logic [31:0] data_a,
  input  logic [31:0] data_b,
  input  logic        input_rdy,
  output logic        input_ack,
  output logic        output_rdy,
  input  logic        output_ack,
  output logic [31:0] result
);

  typedef enum logic [2:0] {
    IDLE, UNPACK, SPECIAL, COMPUTE, NORMALIZE, DONE
  } state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [31:0] QNAN = 32'hFFFF_FFFF;

  state_t state, state_nx;

  logic [3:0]  op;
  logic [31:0] a_q, b_q;
  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;
  logic        r_sign;
  logic signed [10:0] r_exp;
  logic [24:0] r_mant;

  logic is_add, is_mul, is_div, reserved, sbe, sx;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic        spec_hit;
  logic [31:0] spec_val;
  logic        compute_done;

  assign is_add = (op == OP_ADD) || (op == OP_SUB);
  assign is_mul = (op == OP_MUL);
  assign is_div = (op == OP_DIV);
  assign sbe    = sb ^ (op == OP_SUB);
  assign sx     = sa ^ sb;
`ifdef FPU_DIV_EN
  assign reserved = (op > OP_DIV);
`else
  assign reserved = (op > OP_MUL);
`endif

  assign a_nan  = (&ea) && (|a_q[22:0]);
  assign b_nan  = (&eb) && (|b_q[22:0]);
  assign a_inf  = (&ea) && !(|a_q[22:0]);
  assign b_inf  = (&eb) && !(|b_q[22:0]);
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);

  // First match wins, so this decoder must stay priority-ordered.
  always_comb begin
    spec_hit = 1'b1;
    spec_val = '0;
    priority case (1'b1)
      a_nan || b_nan || reserved
        || (is_add && a_inf && b_inf && (sa != sbe))
        || (is_mul && ((a_zero && b_inf) || (a_inf && b_zero)))
        || (is_div && ((a_zero && b_zero) || (a_inf && b_inf))):
        spec_val = QNAN;
      is_add && a_inf:
        spec_val = {sa, 8'hFF, 23'd0};
      is_add && b_inf:
        spec_val = {sbe, 8'hFF, 23'd0};
      is_mul && (a_inf || b_inf):
        spec_val = {sx, 8'hFF, 23'd0};
      is_div && (b_zero || a_inf):
        spec_val = {sx, 8'hFF, 23'd0};
      is_div && b_inf:
        spec_val = {sx, 31'd0};
      is_add && a_zero:
        spec_val = {sbe, eb, mb[22:0]};
      is_add && b_zero:
        spec_val = {sa, ea, ma[22:0]};
      (is_mul || is_div) && (a_zero || b_zero):
        spec_val = {sx, 31'd0};
      default:
        spec_hit = 1'b0;
    endcase
  end

  logic        a_big, add_sign;
  logic [23:0] big_m, small_m, aligned;
  logic [7:0]  big_e, small_e, diff;
  logic [24:0] add_mant;

  always_comb begin
    a_big    = (ea > eb) || ((ea == eb) && (ma >= mb));
    big_m    = a_big ? ma : mb;
    small_m  = a_big ? mb : ma;
    big_e    = a_big ? ea : eb;
    small_e  = a_big ? eb : ea;
    diff     = big_e - small_e;
    aligned  = (diff >= 8'd25) ? 24'd0 : (small_m >> diff);
    add_sign = a_big ? sa : sbe;
    if (sa == sbe)
      add_mant = {1'b0, big_m} + {1'b0, aligned};
    else
      add_mant = {1'b0, big_m} - {1'b0, aligned};
  end

  logic [24:0] prod_hi;
  assign prod_hi = 25'(({24'd0, ma} * {24'd0, mb}) >> 23);

`ifdef FPU_DIV_EN
  logic [25:0] rem, rem_sub, rem_nx;
  logic [25:0] quo, quo_nx;
  logic [4:0]  cnt;
  logic        ge;

  always_comb begin
    ge      = (rem >= {2'b0, mb});
    rem_sub = ge ? (rem - {2'b0, mb}) : rem;
    rem_nx  = 26'(rem_sub << 1);
    quo_nx  = {quo[24:0], ge};
  end

  assign compute_done = !is_div || (cnt == 5'd25);
`else
  assign compute_done = 1'b1;
`endif

  logic [4:0]  lz;
  logic [22:0] norm_m;
  logic signed [10:0] norm_e;
  logic [31:0] norm_val;

  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 24; i++)
      if (r_mant[i]) lz = 5'(23 - i);
    if (r_mant[24]) begin
      norm_m = 23'(r_mant >> 1);
      norm_e = r_exp + 11'sd1;
    end else begin
      norm_m = 23'(r_mant << lz);
      norm_e = r_exp - $signed({6'd0, lz});
    end
    if (r_mant == 25'd0)
      norm_val = 32'd0;
    else if (norm_e >= 11'sd255)
      norm_val = {r_sign, 8'hFF, 23'd0};
    else if (norm_e <= 11'sd0)
      norm_val = {r_sign, 31'd0};
    else
      norm_val = {r_sign, norm_e[7:0], norm_m};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (input_rdy) state_nx = UNPACK;
      UNPACK:    state_nx = SPECIAL;
      SPECIAL:   state_nx = spec_hit ? DONE : COMPUTE;
      COMPUTE:   if (compute_done) state_nx = NORMALIZE;
      NORMALIZE: state_nx = DONE;
      DONE:      if (output_ack) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    input_ack  = (state != IDLE);
    output_rdy = (state == DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op     <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      ea     <= '0;
      eb     <= '0;
      ma     <= '0;
      mb     <= '0;
      r_sign <= 1'b0;
      r_exp  <= '0;
      r_mant <= '0;
      result <= '0;
`ifdef FPU_DIV_EN
      rem    <= '0;
      quo    <= '0;
      cnt    <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: if (input_rdy) begin
          op  <= operation;
          a_q <= data_a;
          b_q <= data_b;
        end
        UNPACK: begin
          sa <= a_q[31];
          sb <= b_q[31];
          ea <= a_q[30:23];
          eb <= b_q[30:23];
          ma <= (|a_q[30:23]) ? {1'b1, a_q[22:0]} : 24'd0;
          mb <= (|b_q[30:23]) ? {1'b1, b_q[22:0]} : 24'd0;
        end
        SPECIAL: begin
          if (spec_hit) result <= spec_val;
`ifdef FPU_DIV_EN
          rem <= {2'b0, ma};
          quo <= '0;
          cnt <= '0;
`endif
        end
        COMPUTE: begin
          if (is_add) begin
            r_sign <= add_sign;
            r_exp  <= $signed({3'd0, big_e});
            r_mant <= add_mant;
          end else if (is_mul) begin
            r_sign <= sx;
            r_exp  <= $signed({3'd0, ea}) + $signed({3'd0, eb}) - 11'sd127;
            r_mant <= prod_hi;
          end
`ifdef FPU_DIV_EN
          else if (is_div) begin
            // q[25] carries weight 1, placed at bit 24 so exponent is one lower.
            rem    <= rem_nx;
            quo    <= quo_nx;
            cnt    <= cnt + 5'd1;
            r_sign <= sx;
            r_exp  <= $signed({3'd0, ea}) - $signed({3'd0, eb}) + 11'sd126;
            r_mant <= quo_nx[25:1];
          end
`endif
        end
        NORMALIZE: result <= norm_val;
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu.sv
// Directed-vector bench for the binary32 fpu: results, latency,
// handshake hold/release and asynchronous abort.
module tb_fpu;

  logic        clock;
  logic        reset;
  logic [3:0]  operation;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic        input_rdy;
  logic        input_ack;
  logic        output_rdy;
  logic        output_ack;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  fpu dut (
    .clock      (clock),
    .reset      (reset),
    .operation  (operation),
    .data_a     (data_a),
    .data_b     (data_b),
    .input_rdy  (input_rdy),
    .input_ack  (input_ack),
    .output_rdy (output_rdy),
    .output_ack (output_ack),
    .result     (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] req);
    tests++;
    if (obs !== req) begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  task automatic start_op(input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, output int lat);
    @(negedge clock);
    operation = o;
    data_a    = a;
    data_b    = b;
    input_rdy = 1'b1;
    lat = 0;
    do begin
      @(posedge clock);
      #1;
      input_rdy = 1'b0;
      lat++;
    end while (!output_rdy && lat < 100);
  endtask

  task automatic ack_op();
    @(negedge clock);
    output_ack = 1'b1;
    @(posedge clock);
    #1;
    output_ack = 1'b0;
  endtask

  task automatic check_op(input string tag, input logic [3:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] req, input int req_lat);
    int lat;
    start_op(o, a, b, lat);
    chk({tag, ".ready"}, {31'd0, output_rdy}, 32'd1);
    chk({tag, ".result"}, result, req);
    chk({tag, ".latency"}, lat, req_lat);
    ack_op();
  endtask

  int lat;
  logic [31:0] held;

  initial begin
    reset      = 1'b1;
    operation  = '0;
    data_a     = '0;
    data_b     = '0;
    input_rdy  = 1'b0;
    output_ack = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset.input_ack", {31'd0, input_ack}, 32'd0);
    chk("reset.output_rdy", {31'd0, output_rdy}, 32'd0);
    chk("reset.result", result, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    start_op(4'd0, 32'h3F800000, 32'h3C23D70A, lat);
    chk("add1.ready", {31'd0, output_rdy}, 32'd1);
    chk("add1.result", result, 32'h3F8147AE);
    chk("add1.latency", lat, 5);
    chk("add1.input_ack", {31'd0, input_ack}, 32'd1);
    held = result;
    repeat (10) @(posedge clock);
    #1;
    chk("hold.output_rdy", {31'd0, output_rdy}, 32'd1);
    chk("hold.result", result, held);
    ack_op();
    chk("ack.output_rdy", {31'd0, output_rdy}, 32'd0);
    chk("ack.input_ack", {31'd0, input_ack}, 32'd0);

    check_op("add_mixed", 4'd0, 32'hBF800000, 32'h41433333, 32'h41333333, 5);
    check_op("add_neg", 4'd0, 32'hBF800000, 32'hC1433333, 32'hC1533333, 5);
    check_op("add_far", 4'd0, 32'h7E967699, 32'hBF8CCCCD, 32'h7E967699, 5);
    check_op("add_carry", 4'd0, 32'h3FC00000, 32'h3FC00000, 32'h40400000, 5);
    check_op("add_inf", 4'd0, 32'h7F800000, 32'h3F800000, 32'h7F800000, 3);
    check_op("add_nan", 4'd0, 32'hFF8CCCCD, 32'h7F8CCCCD, 32'hFFFFFFFF, 3);
    check_op("add_inf_inf", 4'd0, 32'h7F800000, 32'hFF800000, 32'hFFFFFFFF, 3);
    check_op("add_zero", 4'd0, 32'h00000000, 32'hC0400000, 32'hC0400000, 3);
    check_op("sub_cancel", 4'd1, 32'h3F800000, 32'h3F800000, 32'h00000000, 5);
    check_op("sub_3m1", 4'd1, 32'h40400000, 32'h3F800000, 32'h40000000, 5);
    check_op("sub_inf", 4'd1, 32'h3F800000, 32'h7F800000, 32'hFF800000, 3);
    check_op("mul_2x2", 4'd2, 32'h40000000, 32'h40000000, 32'h40800000, 5);
    check_op("mul_n2x2", 4'd2, 32'hC0000000, 32'h40000000, 32'hC0800000, 5);
    check_op("mul_zero", 4'd2, 32'hC0400000, 32'h00000000, 32'h80000000, 3);
    check_op("mul_0inf", 4'd2, 32'h00000000, 32'h7F800000, 32'hFFFFFFFF, 3);
    check_op("mul_ovf", 4'd2, 32'h7F000000, 32'h40000000, 32'h7F800000, 5);
    check_op("mul_unf", 4'd2, 32'h00800000, 32'h3F000000, 32'h00000000, 5);
    check_op("reserved", 4'd5, 32'h3F800000, 32'h3F800000, 32'hFFFFFFFF, 3);
`ifdef FPU_DIV_EN
    check_op("div_4d2", 4'd3, 32'h40800000, 32'h40000000, 32'h40000000, 30);
    check_op("div_1d3", 4'd3, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 30);
    check_op("div_by0", 4'd3, 32'h3F800000, 32'h00000000, 32'h7F800000, 3);
`else
    check_op("div_off", 4'd3, 32'h40800000, 32'h40000000, 32'hFFFFFFFF, 3);
`endif

    @(negedge clock);
    operation = 4'd3;
    data_a    = 32'h40800000;
    data_b    = 32'h40000000;
    input_rdy = 1'b1;
    @(posedge clock);
    #1;
    input_rdy = 1'b0;
    chk("abort.busy", {31'd0, input_ack}, 32'd1);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("abort.input_ack", {31'd0, input_ack}, 32'd0);
    chk("abort.output_rdy", {31'd0, output_rdy}, 32'd0);
    chk("abort.result", result, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    check_op("post_reset_add", 4'd0, 32'h3F800000, 32'h3F800000,
             32'h40000000, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
